imm_extend_pipe: RTL

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 106 ++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate extender (zero/sign/upper/branch) feeding a 2-entry result FIFO.
// Latency: 1 cycle from input acceptance to out_valid when the FIFO is empty.
// Backpressure: in_ready drops while both FIFO entries are full; out_data holds while stalled.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      ext_neg_count
);

  localparam int PAD = OUT_W - IN_W;

  typedef enum logic [1:0] {
    MODE_ZEXT  = 2'b00,
    MODE_SEXT  = 2'b01,
    MODE_UPPER = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  logic [OUT_W-1:0] mem_q [2];
  logic [OUT_W-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [15:0]      neg_q, neg_d;

  logic             push;
  logic             pop;
  logic             neg_hit;
  logic [OUT_W-1:0] sext_res;
  logic [OUT_W-1:0] ext_res;

  // Extension datapath: all four results derive from the same immediate.
  always_comb begin
    sext_res = {{PAD{in_data[IN_W-1]}}, in_data};
    ext_res  = '0;
    case (mode_e'(in_mode))
      MODE_ZEXT:   ext_res = {{PAD{1'b0}}, in_data};
      MODE_SEXT:   ext_res = sext_res;
      MODE_UPPER:  ext_res = {in_data, {PAD{1'b0}}};
      MODE_BRANCH: ext_res = {sext_res[OUT_W-3:0], 2'b00};
      default:     ext_res = '0;
    endcase
  end

  // Handshake view of the FIFO; count==0 forces out_data to zero (also during reset).
  always_comb begin
    in_ready  = (count_q != 2'd2) && !Reset;
    out_valid = (count_q != 2'd0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    neg_hit   = push && in_mode[0] && in_data[IN_W-1];
  end

  // Next-state: write at wr_ptr, read at rd_ptr, both pointers wrap modulo 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    neg_d    = neg_q + {15'd0, neg_hit};
    if (push) begin
      mem_d[wr_ptr_q] = ext_res;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards buffered results without waiting for an edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      neg_q    <= 16'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
    end
  end

  assign ext_neg_count = neg_q;

endmodule
